pwr_seq_unit: RTL and testbench
===============================

PWR_SEQ_UNIT -- requirements
Module: pwr_seq_unit

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, APB address width.
REQ-002 SHALL have parameter N_BANKS, default 4, range 1..16, number of independently gated memory banks.
REQ-003 SHALL have parameter DLY_WIDTH, default 8, width of the per-bank wake delay in low-speed ticks.
REQ-004 SHALL have ports, in this order:
- HCLK  in  1  sole clock.
- HRESETn  in  1  asynchronous active-low reset.
- clk32_i  in  1  asynchronous low-speed reference.
- PADDR  in  APB_ADDR_WIDTH, PWDATA in 32, PWRITE/PSEL/PENABLE in 1  APB slave.
- PRDATA  out 32, PREADY out 1, PSLVERR out 1  APB slave.
- irq_i, event_i, core_busy_i  in  1  wake and busy inputs.
- fetch_en_o, clk_gate_core_o  out  1  core control; gate blocks the clock when low.
- mem_sleep_o  out  1  memory retention request.
- mem_gate_o  out  N_BANKS  per-bank power switch; 1 = bank off.

Function
REQ-005 SHALL decode PADDR[5:2]: 0 CTRL (rw; bit0 SLEEP_EN, bit1 EXT_EN), 1 STATUS (ro; bit0 sleeping, bit1 ext_sleeping, bits[6:4] state code), 2 DELAY (rw, DLY_WIDTH bits), 3 GATE_MASK (rw, N_BANKS bits).
REQ-006 SHALL hold PREADY=1 and PSLVERR=0; reads of unmapped offsets SHALL return 0; PRDATA SHALL be 0 outside a read access phase.
REQ-007 SHALL write registers on PSEL&PENABLE&PWRITE, effective the next HCLK cycle; an APB write SHALL take priority over a same-cycle hardware clear.
REQ-008 SHALL detect clk32_i rising edges with a 3-flop synchronizer, producing a one-HCLK tick pulse.
REQ-009 SHALL implement FSM states RUN(0), SHUTDOWN(1), SLEEP(2), EXT_SLEEP(3), WAKEUP(4); illegal codes SHALL return to RUN.
REQ-010 RUN->SHUTDOWN when SLEEP_EN=1 and event_i=0; in RUN, fetch_en_o SHALL be 0 combinationally while SLEEP_EN=1 and event_i=0.
REQ-011 SHUTDOWN: fetch_en_o=0; event_i->RUN; else core_busy_i=0 and irq_i=0 ->SLEEP.
REQ-012 SLEEP: clk_gate_core_o=event_i; event_i->RUN; else irq_i->SHUTDOWN; else EXT_EN=1 ->EXT_SLEEP.
REQ-013 EXT_SLEEP: clk_gate_core_o=0, mem_sleep_o=1, mem_gate_o=GATE_MASK (latched on entry); irq_i ignored; event_i->WAKEUP with bank pointer 0 and tick counter 0.
REQ-014 WAKEUP SHALL process banks in ascending index: a bank with latched gate=0 is skipped in one HCLK; a gated bank has its bit cleared once the tick counter reaches DELAY, then the pointer advances and the counter resets.
REQ-015 After the last bank, mem_sleep_o SHALL deassert and the FSM SHALL enter RUN in the next cycle; DELAY=0 SHALL ungate one gated bank per HCLK cycle.
REQ-016 SLEEP_EN SHALL clear while sleeping or when event_i=1; EXT_EN SHALL clear while ext_sleeping or when event_i=1.
REQ-017 ext_sleeping SHALL be 1 in EXT_SLEEP and WAKEUP; sleeping SHALL be 1 only in SLEEP.
REQ-018 DELAY and GATE_MASK writes during WAKEUP SHALL NOT affect the sequence in progress.

Reset
REQ-019 On HRESETn low: state RUN, all registers 0, pointer and counter 0, synchronizer 0; fetch_en_o=1, clk_gate_core_o=1, mem_sleep_o=0, mem_gate_o=0.
REQ-020 Reset asserted mid-WAKEUP SHALL immediately ungate all banks.

Configuration
REQ-021 With SLEEP_WAKE_CNT_EN defined, offset 4 SHALL be a 16-bit saturating count of EXT_SLEEP->WAKEUP transitions, cleared by any write; without it, offset 4 reads 0 and no counter exists.

Verification
REQ-022 Write CTRL=1, core_busy_i=0, irq_i=0 -> SHUTDOWN then SLEEP; clk_gate_core_o=0; STATUS reads 0x21.
REQ-023 CTRL=3, GATE_MASK=0xF, DELAY=2, event_i pulse -> banks 0..3 ungate in order, each 2 ticks apart; mem_sleep_o falls after bank 3; RUN follows.
REQ-024 GATE_MASK=0x5, DELAY=0 -> banks 1 and 3 never gated; WAKEUP lasts 4 HCLK cycles.
REQ-025 event_i during SHUTDOWN -> RUN next cycle, SLEEP_EN reads 0, fetch_en_o=1.
REQ-026 HRESETn low in WAKEUP with mem_gate_o=0xC -> mem_gate_o=0 and fetch_en_o=1 without waiting for an HCLK edge.
REQ-027 With SLEEP_WAKE_CNT_EN, three ext-sleep wakes -> offset 4 reads 3; a write to it -> reads 0.

Source files
------------

// File: rtl/pwr_seq_unit.sv
// pwr_seq_unit: APB-controlled core sleep sequencer with staged per-bank memory wake-up.
// Optional feature macro SLEEP_WAKE_CNT_EN adds a saturating ext-sleep wake counter at offset 4.
module pwr_seq_unit #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_BANKS        = 4,
    parameter int DLY_WIDTH      = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      clk32_i,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic                      irq_i,
    input  logic                      event_i,
    input  logic                      core_busy_i,
    output logic                      fetch_en_o,
    output logic                      clk_gate_core_o,
    output logic                      mem_sleep_o,
    output logic [N_BANKS-1:0]        mem_gate_o
);
    localparam int PTR_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;
    localparam logic [PTR_W-1:0] LAST_BANK = PTR_W'(N_BANKS - 1);

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_SHUTDOWN  = 3'd1,
        ST_SLEEP     = 3'd2,
        ST_EXT_SLEEP = 3'd3,
        ST_WAKEUP    = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic                   sleep_en_q, sleep_en_d, ext_en_q, ext_en_d;
    logic [DLY_WIDTH-1:0]   delay_q, delay_d, dly_lat_q, dly_lat_d, cnt_q, cnt_d;
    logic [N_BANKS-1:0]     gate_mask_q, gate_mask_d, gate_q, gate_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [2:0]             sync_q;
    logic                   tick, wr_en, rd_en, sleeping, ext_sleeping;
    logic [3:0]             offset;
    logic [31:0]            wake_cnt_rd;
    logic                   unused_bits;

    assign wr_en        = PSEL & PENABLE & PWRITE;
    assign rd_en        = PSEL & PENABLE & ~PWRITE;
    assign offset       = PADDR[5:2];
    assign tick         = sync_q[1] & ~sync_q[2];
    assign sleeping     = (state_q == ST_SLEEP);
    assign ext_sleeping = (state_q == ST_EXT_SLEEP) || (state_q == ST_WAKEUP);
    assign PREADY       = 1'b1;
    assign PSLVERR      = 1'b0;
    assign mem_gate_o   = gate_q;
    assign unused_bits  = ^{PWDATA, PADDR};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_RUN;
            sleep_en_q  <= 1'b0;
            ext_en_q    <= 1'b0;
            delay_q     <= '0;
            dly_lat_q   <= '0;
            cnt_q       <= '0;
            gate_mask_q <= '0;
            gate_q      <= '0;
            ptr_q       <= '0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            sleep_en_q  <= sleep_en_d;
            ext_en_q    <= ext_en_d;
            delay_q     <= delay_d;
            dly_lat_q   <= dly_lat_d;
            cnt_q       <= cnt_d;
            gate_mask_q <= gate_mask_d;
            gate_q      <= gate_d;
            ptr_q       <= ptr_d;
            sync_q      <= {sync_q[1:0], clk32_i};
        end
    end

    // Register file: hardware clears first so a same-cycle APB write wins.
    always_comb begin
        sleep_en_d  = sleep_en_q;
        ext_en_d    = ext_en_q;
        delay_d     = delay_q;
        gate_mask_d = gate_mask_q;
        if (sleeping || event_i) sleep_en_d = 1'b0;
        if (ext_sleeping || event_i) ext_en_d = 1'b0;
        if (wr_en) begin
            case (offset)
                4'd0: begin
                    sleep_en_d = PWDATA[0];
                    ext_en_d   = PWDATA[1];
                end
                4'd2:    delay_d     = PWDATA[DLY_WIDTH-1:0];
                4'd3:    gate_mask_d = PWDATA[N_BANKS-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d         = state_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        gate_d          = gate_q;
        dly_lat_d       = dly_lat_q;
        fetch_en_o      = 1'b0;
        clk_gate_core_o = 1'b1;
        mem_sleep_o     = 1'b0;
        case (state_q)
            ST_RUN: begin
                fetch_en_o = ~(sleep_en_q & ~event_i);
                if (sleep_en_q && !event_i) state_d = ST_SHUTDOWN;
            end
            ST_SHUTDOWN: begin
                if (event_i) state_d = ST_RUN;
                else if (!core_busy_i && !irq_i) state_d = ST_SLEEP;
            end
            ST_SLEEP: begin
                clk_gate_core_o = event_i;
                if (event_i) state_d = ST_RUN;
                else if (irq_i) state_d = ST_SHUTDOWN;
                else if (ext_en_q) begin
                    state_d = ST_EXT_SLEEP;
                    gate_d  = gate_mask_q;
                end
            end
            ST_EXT_SLEEP: begin
                clk_gate_core_o = 1'b0;
                mem_sleep_o     = 1'b1;
                if (event_i) begin
                    state_d   = ST_WAKEUP;
                    ptr_d     = '0;
                    cnt_d     = '0;
                    dly_lat_d = delay_q;
                end
            end
            ST_WAKEUP: begin
                clk_gate_core_o = 1'b0;
                mem_sleep_o     = 1'b1;
                // Ungated banks fall through in one cycle; gated ones wait out the latched delay.
                if (!gate_q[ptr_q] || (cnt_q >= dly_lat_q)) begin
                    gate_d[ptr_q] = 1'b0;
                    cnt_d         = '0;
                    if (ptr_q == LAST_BANK) begin
                        state_d = ST_RUN;
                        ptr_d   = '0;
                    end else begin
                        ptr_d = ptr_q + PTR_W'(1);
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + DLY_WIDTH'(1);
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

`ifdef SLEEP_WAKE_CNT_EN
    logic [15:0] wake_cnt_q, wake_cnt_d;

    always_comb begin
        wake_cnt_d = wake_cnt_q;
        if (state_q == ST_EXT_SLEEP && event_i && wake_cnt_q != 16'hFFFF)
            wake_cnt_d = wake_cnt_q + 16'd1;
        if (wr_en && offset == 4'd4) wake_cnt_d = '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) wake_cnt_q <= '0;
        else          wake_cnt_q <= wake_cnt_d;
    end

    assign wake_cnt_rd = {16'd0, wake_cnt_q};
`else
    assign wake_cnt_rd = 32'd0;
`endif

    always_comb begin
        PRDATA = 32'd0;
        if (rd_en) begin
            case (offset)
                4'd0:    PRDATA = {30'd0, ext_en_q, sleep_en_q};
                4'd1:    PRDATA = {25'd0, state_q, 2'b00, ext_sleeping, sleeping};
                4'd2:    PRDATA = 32'(delay_q);
                4'd3:    PRDATA = 32'(gate_mask_q);
                4'd4:    PRDATA = wake_cnt_rd;
                default: PRDATA = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_pwr_seq_unit.sv
// tb_pwr_seq_unit: directed scenarios plus randomized traffic, every cycle compared against
// a behavioural model built from the power-sequencing rules (bank queue, tick history).
module tb_pwr_seq_unit;
    localparam int N = 4;
    localparam int M_RUN = 0, M_SHUT = 1, M_SLEEP = 2, M_EXT = 3, M_WAKE = 4;

    logic        HCLK = 1'b0, HRESETn = 1'b0, clk32_i = 1'b0;
    logic [11:0] PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        irq_i = 1'b0, event_i = 1'b0, core_busy_i = 1'b0;
    logic        fetch_en_o, clk_gate_core_o, mem_sleep_o;
    logic [N-1:0] mem_gate_o;

    int n_cmp = 0, n_err = 0;

    // behavioural model state
    int          m_mode;
    bit          m_sleep_en, m_ext_en;
    logic [7:0]  m_delay;
    logic [3:0]  m_mask, m_gate;
    int          m_pend[$];
    int          m_waited, m_wdelay, m_wake_cnt;
    bit          m_hist[$];

    int          c32_cnt = 0, c32_half = 2;
    logic [31:0] rd_capture;
    logic [3:0]  prev_gate, gate_or;
    logic [3:0]  seq[$];
    int          wake_len, apb_ph;
    logic [31:0] rd_val;

    pwr_seq_unit #(.APB_ADDR_WIDTH(12), .N_BANKS(N), .DLY_WIDTH(8)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .clk32_i(clk32_i),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .irq_i(irq_i), .event_i(event_i), .core_busy_i(core_busy_i),
        .fetch_en_o(fetch_en_o), .clk_gate_core_o(clk_gate_core_o),
        .mem_sleep_o(mem_sleep_o), .mem_gate_o(mem_gate_o)
    );

    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_RUN; m_sleep_en = 0; m_ext_en = 0;
        m_delay = '0; m_mask = '0; m_gate = '0;
        m_pend.delete(); m_waited = 0; m_wdelay = 0; m_wake_cnt = 0;
        m_hist.delete();
        repeat (3) m_hist.push_back(1'b0);
    endtask

    function automatic logic [31:0] m_read(input int off);
        case (off)
            0: return {30'd0, m_ext_en, m_sleep_en};
            1: return {25'd0, 3'(m_mode), 2'b00, (m_mode == M_EXT || m_mode == M_WAKE), (m_mode == M_SLEEP)};
            2: return 32'(m_delay);
            3: return 32'(m_mask);
`ifdef SLEEP_WAKE_CNT_EN
            4: return 32'(m_wake_cnt);
`endif
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one HCLK edge using the inputs present at that edge.
    task automatic model_edge();
        bit tick, wr;
        int off, nmode, b;
        tick  = m_hist[1] && !m_hist[2];
        wr    = PSEL && PENABLE && PWRITE;
        off   = int'(PADDR[5:2]);
        nmode = m_mode;
        case (m_mode)
            M_RUN:  if (m_sleep_en && !event_i) nmode = M_SHUT;
            M_SHUT: if (event_i) nmode = M_RUN; else if (!core_busy_i && !irq_i) nmode = M_SLEEP;
            M_SLEEP: begin
                if (event_i) nmode = M_RUN;
                else if (irq_i) nmode = M_SHUT;
                else if (m_ext_en) begin nmode = M_EXT; m_gate = m_mask; end
            end
            M_EXT: if (event_i) begin
                nmode = M_WAKE;
                m_pend.delete();
                for (int i = 0; i < N; i++) m_pend.push_back(i);
                m_waited = 0;
                m_wdelay = int'(m_delay);
                if (m_wake_cnt < 65535) m_wake_cnt++;
            end
            M_WAKE: begin
                b = m_pend[0];
                if (!m_gate[b] || m_waited >= m_wdelay) begin
                    m_gate[b] = 1'b0;
                    void'(m_pend.pop_front());
                    m_waited = 0;
                    if (m_pend.size() == 0) nmode = M_RUN;
                end else if (tick) m_waited++;
            end
            default: nmode = M_RUN;
        endcase
        if (m_mode == M_SLEEP || event_i) m_sleep_en = 0;
        if (m_mode == M_EXT || m_mode == M_WAKE || event_i) m_ext_en = 0;
        if (wr) begin
            case (off)
                0: begin m_sleep_en = PWDATA[0]; m_ext_en = PWDATA[1]; end
                2: m_delay = PWDATA[7:0];
                3: m_mask = PWDATA[3:0];
                4: m_wake_cnt = 0;
                default: ;
            endcase
        end
        m_mode = nmode;
        m_hist.push_front(clk32_i);
        void'(m_hist.pop_back());
    endtask

    task automatic compare();
        bit fe, cg, ms;
        logic [31:0] exp_rd;
        fe = (m_mode == M_RUN) && !(m_sleep_en && !event_i);
        cg = (m_mode == M_RUN || m_mode == M_SHUT) ? 1'b1 : (m_mode == M_SLEEP) ? event_i : 1'b0;
        ms = (m_mode == M_EXT || m_mode == M_WAKE);
        exp_rd = (PSEL && PENABLE && !PWRITE) ? m_read(int'(PADDR[5:2])) : 32'd0;
        rd_capture = PRDATA;
        chk("fetch_en", 32'(fetch_en_o), 32'(fe));
        chk("clk_gate", 32'(clk_gate_core_o), 32'(cg));
        chk("mem_sleep", 32'(mem_sleep_o), 32'(ms));
        chk("mem_gate", 32'(mem_gate_o), 32'(m_gate));
        chk("prdata", PRDATA, exp_rd);
        chk("pready", 32'(PREADY), 32'd1);
        chk("pslverr", 32'(PSLVERR), 32'd0);
    endtask

    task automatic cycle();
        @(negedge HCLK);
        compare();
        @(posedge HCLK);
        model_edge();
        #1;
        c32_cnt++;
        if (c32_cnt >= c32_half) begin clk32_i = ~clk32_i; c32_cnt = 0; end
    endtask

    task automatic reset_seq();
        HRESETn = 1'b0;
        model_reset();
        @(negedge HCLK);
        compare();
        @(posedge HCLK);
        #1 HRESETn = 1'b1;
    endtask

    task automatic apb_wr(input int off, input logic [31:0] d);
        PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = 12'(off * 4); PWDATA = d;
        cycle();
        PENABLE = 1;
        cycle();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        $display("apb write off=%0d data=0x%0h", off, d);
    endtask

    task automatic apb_rd(input int off, output logic [31:0] d);
        PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = 12'(off * 4);
        cycle();
        PENABLE = 1;
        cycle();
        d = rd_capture;
        PSEL = 0; PENABLE = 0;
        $display("apb read  off=%0d data=0x%0h", off, d);
    endtask

    task automatic go_ext();
        apb_wr(0, 32'd3);
        for (int k = 0; k < 40 && !mem_sleep_o; k++) cycle();
        chk("reach_ext", 32'(mem_sleep_o), 32'd1);
    endtask

    task automatic wake_pulse();
        event_i = 1; cycle(); event_i = 0;
    endtask

    initial begin
        model_reset();
        reset_seq();
        chk("rst_fetch", 32'(fetch_en_o), 32'd1);
        chk("rst_gate", 32'(mem_gate_o), 32'd0);

        // Sleep entry and STATUS encoding
        apb_wr(0, 32'd1);
        repeat (3) cycle();
        chk("sleep_clk_gate", 32'(clk_gate_core_o), 32'd0);
        apb_rd(1, rd_val);
        chk("status_sleep", rd_val, 32'h21);
        wake_pulse();
        cycle();

        // Event while in SHUTDOWN
        core_busy_i = 1;
        apb_wr(0, 32'd1);
        repeat (2) cycle();
        wake_pulse();
        chk("shut_ev_fetch", 32'(fetch_en_o), 32'd1);
        core_busy_i = 0;
        apb_rd(0, rd_val);
        chk("shut_ev_sleep_en", rd_val & 32'd1, 32'd0);

        // Full staged wake: all banks gated, DELAY=2
        apb_wr(2, 32'd2);
        apb_wr(3, 32'hF);
        go_ext();
        chk("ext_gate", 32'(mem_gate_o), 32'hF);
        wake_pulse();
        seq.delete();
        prev_gate = mem_gate_o;
        for (int k = 0; k < 300 && mem_sleep_o; k++) begin
            cycle();
            if (mem_gate_o != prev_gate) begin seq.push_back(mem_gate_o); prev_gate = mem_gate_o; end
        end
        chk("wake_done", 32'(mem_sleep_o), 32'd0);
        chk("order_len", 32'(seq.size()), 32'd4);
        if (seq.size() == 4) begin
            chk("order0", 32'(seq[0]), 32'hE);
            chk("order1", 32'(seq[1]), 32'hC);
            chk("order2", 32'(seq[2]), 32'h8);
            chk("order3", 32'(seq[3]), 32'h0);
        end
        cycle();
        apb_rd(1, rd_val);
        chk("status_run", rd_val, 32'h0);

        // Sparse mask with zero delay
        apb_wr(2, 32'd0);
        apb_wr(3, 32'h5);
        go_ext();
        wake_pulse();
        wake_len = 0;
        gate_or = '0;
        for (int k = 0; k < 20; k++) begin
            if (mem_sleep_o) wake_len++;
            gate_or = gate_or | mem_gate_o;
            cycle();
        end
        chk("wake_len", 32'(wake_len), 32'd4);
        chk("never_gated", 32'(gate_or & 4'hA), 32'd0);

`ifdef SLEEP_WAKE_CNT_EN
        reset_seq();
        for (int w = 0; w < 3; w++) begin
            go_ext();
            wake_pulse();
            for (int k = 0; k < 20 && mem_sleep_o; k++) cycle();
        end
        apb_rd(4, rd_val);
        chk("wake_cnt3", rd_val, 32'd3);
        apb_wr(4, 32'h1234);
        apb_rd(4, rd_val);
        chk("wake_cnt_clr", rd_val, 32'd0);
`endif

        // Asynchronous reset in the middle of a wake sequence
        apb_wr(2, 32'd3);
        apb_wr(3, 32'hF);
        go_ext();
        wake_pulse();
        for (int k = 0; k < 300 && mem_gate_o != 4'hC; k++) cycle();
        chk("pre_rst_gate", 32'(mem_gate_o), 32'hC);
        #1 HRESETn = 1'b0;
        #1;
        chk("async_rst_gate", 32'(mem_gate_o), 32'd0);
        chk("async_rst_fetch", 32'(fetch_en_o), 32'd1);
        chk("async_rst_msleep", 32'(mem_sleep_o), 32'd0);
        reset_seq();

        // Randomized traffic against the model
        apb_ph = 0;
        for (int i = 0; i < 3000; i++) begin
            event_i     = ($urandom_range(0, 15) == 0);
            irq_i       = ($urandom_range(0, 3) == 0);
            core_busy_i = ($urandom_range(0, 2) == 0);
            if (c32_cnt == 0) c32_half = $urandom_range(1, 4);
            case (apb_ph)
                0: if ($urandom_range(0, 2) == 0) begin
                    PSEL = 1; PENABLE = 0; PWRITE = $urandom_range(0, 1);
                    PADDR = 12'($urandom_range(0, 7) * 4);
                    case (PADDR[5:2])
                        4'd0, 4'd2: PWDATA = $urandom_range(0, 3);
                        default:    PWDATA = $urandom;
                    endcase
                    apb_ph = 1;
                end
                1: begin PENABLE = 1; apb_ph = 2; end
                default: begin PSEL = 0; PENABLE = 0; PWRITE = 0; apb_ph = 0; end
            endcase
            cycle();
        end
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
